// File: rtl/shift_rotate_engine_if.sv
// Operand/control bundle for shift_rotate_engine: the launching FSM is the master,
// the engine is the slave.
interface shift_rotate_engine_if #(
   parameter int N  = 25,
   parameter int CW = 5
);
   logic          start;
   logic [1:0]    mode;
   logic [CW-1:0] amount;
   logic          cin;
   logic [N-1:0]  pin;
   logic [N-1:0]  pout;
   logic          busy;
   logic          done;

   modport master (
      output start, mode, amount, cin, pin,
      input  pout, busy, done
   );

   modport slave (
      input  start, mode, amount, cin, pin,
      output pout, busy, done
   );
endinterface

// File: rtl/shift_rotate_engine.sv
// Multi-cycle shift/rotate engine: loads a word, then moves it up to STEP positions
// per clock until the requested amount is consumed, pulsing done at the end.
module shift_rotate_engine #(
   parameter int N    = 25,
   parameter int CW   = 5,
   parameter int STEP = 1
) (
   input logic                 clk,
   input logic                 rst,
   shift_rotate_engine_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [N-1:0] ONES   = '1;
   localparam int unsigned  STEP_U = STEP;
   localparam int unsigned  N_U    = N;

   state_t        state;
   state_t        next_state;
   logic [N-1:0]  pout_q;
   logic [N-1:0]  pout_next;
   logic [N-1:0]  shifted;
   logic [CW-1:0] remaining;
   logic [CW-1:0] remaining_next;
   logic [1:0]    mode_q;
   logic          cin_q;
   logic          busy_q;
   logic          done_q;
   int unsigned   k;

   // k never exceeds N, so the rotate's complementary shift (N - k) stays non-negative.
   always_comb begin
      k = 32'(remaining);
      if (k > STEP_U) begin
         k = STEP_U;
      end
      case (mode_q)
         2'd0:    shifted = (pout_q << k) | (cin_q ? ~(ONES << k) : '0);
         2'd1:    shifted = (pout_q >> k) | (cin_q ? ~(ONES >> k) : '0);
         2'd2:    shifted = (pout_q << k) | (pout_q >> (N_U - k));
         default: shifted = (pout_q >> k) | (pout_q << (N_U - k));
      endcase
   end

   always_comb begin
      next_state     = state;
      pout_next      = pout_q;
      remaining_next = remaining;
      case (state)
         IDLE: begin
            if (bus.start) begin
               pout_next      = bus.pin;
               remaining_next = bus.amount;
               next_state     = (bus.amount == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            pout_next      = shifted;
            remaining_next = remaining - CW'(k);
            if (remaining_next == '0) begin
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // busy/done come from flops fed by next_state, so they line up with the state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pout_q    <= '0;
         remaining <= '0;
         mode_q    <= '0;
         cin_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         pout_q    <= pout_next;
         remaining <= remaining_next;
         busy_q    <= (next_state == RUN);
         done_q    <= (next_state == DONE);
         if (state == IDLE && bus.start) begin
            mode_q <= bus.mode;
            cin_q  <= bus.cin;
         end
      end
   end

   assign bus.pout = pout_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

// File: tb/tb_shift_rotate_engine.sv
// Bench for shift_rotate_engine: runs every operation on a STEP=1 and a STEP=4 build
// side by side and compares each cycle against an arithmetic reference model.
module tb_shift_rotate_engine;

   localparam int N  = 25;
   localparam int CW = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checkCount = 0;
   int   failCount  = 0;

   always #5 clk = ~clk;

   shift_rotate_engine_if #(.N(N), .CW(CW)) ifA ();
   shift_rotate_engine_if #(.N(N), .CW(CW)) ifB ();

   shift_rotate_engine #(.N(N), .CW(CW), .STEP(1)) dutA (.clk(clk), .rst(rst), .bus(ifA));
   shift_rotate_engine #(.N(N), .CW(CW), .STEP(4)) dutB (.clk(clk), .rst(rst), .bus(ifB));

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Closed-form result of moving p by 'moved' positions in mode m.
   function automatic logic [N-1:0] refModel(input logic [N-1:0] p, input logic [1:0] m,
                                              input logic c, input int moved);
      longint unsigned w, mask, r;
      int rot;
      w    = 64'(p);
      mask = (64'd1 << N) - 64'd1;
      rot  = moved % N;
      case (m)
         2'd0:    r = (w << moved) | (c ? ((64'd1 << moved) - 64'd1) : 64'd0);
         2'd1:    r = (w >> moved) | (c ? (mask & ~(mask >> moved)) : 64'd0);
         2'd2:    r = (w << rot) | (w >> (N - rot));
         default: r = (w >> rot) | (w << (N - rot));
      endcase
      return N'(r & mask);
   endfunction

   task automatic scrambleInputs();
      ifA.pin    = N'($urandom);
      ifA.mode   = 2'($urandom);
      ifA.amount = CW'($urandom);
      ifA.cin    = 1'($urandom);
      ifB.pin    = N'($urandom);
      ifB.mode   = 2'($urandom);
      ifB.amount = CW'($urandom);
      ifB.cin    = 1'($urandom);
   endtask

   task automatic checkDut(input string name, input int j, input int step, input int r,
                           input logic [1:0] m, input int a, input logic c, input logic [N-1:0] p,
                           input logic [N-1:0] pout, input logic busy, input logic done);
      int moved;
      moved = (j * step < a) ? j * step : a;
      checkOutput($sformatf("%s.pout m%0d a%0d j%0d", name, m, a, j), 32'(pout), 32'(refModel(p, m, c, moved)));
      checkOutput($sformatf("%s.busy m%0d a%0d j%0d", name, m, a, j), 32'(busy), 32'(j < r));
      checkOutput($sformatf("%s.done m%0d a%0d j%0d", name, m, a, j), 32'(done), 32'(j == r));
   endtask

   // Launch one operation on both builds and check every cycle until both are idle again.
   task automatic applyStimulus(input logic [1:0] m, input int a, input logic c,
                                input logic [N-1:0] p, input bit holdStart);
      int rA, rB, rMax;
      rA   = a;
      rB   = (a + 3) / 4;
      rMax = (rA > rB) ? rA : rB;
      ifA.mode = m;  ifA.amount = CW'(a);  ifA.cin = c;  ifA.pin = p;  ifA.start = 1'b1;
      ifB.mode = m;  ifB.amount = CW'(a);  ifB.cin = c;  ifB.pin = p;  ifB.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int j = 0; j <= rMax + 1; j++) begin
         checkDut("A", j, 1, rA, m, a, c, p, ifA.pout, ifA.busy, ifA.done);
         checkDut("B", j, 4, rB, m, a, c, p, ifB.pout, ifB.busy, ifB.done);
         if (!holdStart || j >= rA + 1) ifA.start = 1'b0;
         if (!holdStart || j >= rB + 1) ifB.start = 1'b0;
         scrambleInputs();
         @(negedge clk);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".A.pout"}, 32'(ifA.pout), 32'd0);
      checkOutput({tag, ".A.busy"}, 32'(ifA.busy), 32'd0);
      checkOutput({tag, ".A.done"}, 32'(ifA.done), 32'd0);
      checkOutput({tag, ".B.pout"}, 32'(ifB.pout), 32'd0);
      checkOutput({tag, ".B.busy"}, 32'(ifB.busy), 32'd0);
      checkOutput({tag, ".B.done"}, 32'(ifB.done), 32'd0);
   endtask

   initial begin
      ifA.start = 1'b0;  ifA.mode = '0;  ifA.amount = '0;  ifA.cin = 1'b0;  ifA.pin = '0;
      ifB.start = 1'b0;  ifB.mode = '0;  ifB.amount = '0;  ifB.cin = 1'b0;  ifB.pin = '0;

      repeat (2) @(negedge clk);
      checkAllZero("reset");
      rst = 1'b1;
      @(negedge clk);

      applyStimulus(2'd2, 3, 1'b0, 25'h1000001, 1'b0);
      checkOutput("T1.final", 32'(ifA.pout), 32'h000000C);

      applyStimulus(2'd0, 4, 1'b1, 25'h0000000, 1'b0);
      checkOutput("T2.final", 32'(ifA.pout), 32'h000000F);

      applyStimulus(2'd1, 30, 1'b0, 25'h1FFFFFF, 1'b0);
      checkOutput("T3.final", 32'(ifA.pout), 32'h0);

      applyStimulus(2'd1, 0, 1'b1, 25'h0ABCDEF, 1'b0);
      checkOutput("T4.final", 32'(ifA.pout), 32'h0ABCDEF);

      applyStimulus(2'd3, 5, 1'b0, 25'h1234567, 1'b1);

      applyStimulus(2'd3, 10, 1'b0, 25'h0000001, 1'b0);
      checkOutput("T6.final", 32'(ifB.pout), 32'h0008000);

      // Mid-run reset: assert during the second RUN cycle and look before the next edge.
      ifA.mode = 2'd2;  ifA.amount = 5'd5;  ifA.cin = 1'b0;  ifA.pin = 25'h0F0F0F0;  ifA.start = 1'b1;
      ifB.mode = 2'd2;  ifB.amount = 5'd5;  ifB.cin = 1'b0;  ifB.pin = 25'h0F0F0F0;  ifB.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ifA.start = 1'b0;
      ifB.start = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checkAllZero("T5.async");
      @(negedge clk);
      rst = 1'b1;
      repeat (3) begin
         scrambleInputs();
         @(negedge clk);
         checkAllZero("T5.idle");
      end

      for (int i = 0; i < 24; i++) begin
         applyStimulus(2'($urandom), int'($urandom_range(0, 31)), 1'($urandom),
                       N'($urandom), ($urandom_range(0, 3) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/shift_rotate_engine.md
# shift_rotate_engine

Parametrised multi-mode shift/rotate unit that loads an N-bit word, then shifts or rotates it by a run-time amount over multiple clock cycles, moving up to STEP positions per cycle. It replaces the single-position shift register in the matrix-encoder datapath with one start/busy/done-controlled engine. The permutation and encoder control FSMs launch an operation and wait for `done` instead of sequencing shift enables themselves.

## Interface
- N, 25, data width in bits (N ≥ 2)
- CW, 5, width of the shift-amount field; amounts 0..2^CW−1
- STEP, 1, maximum positions moved per cycle (1 ≤ STEP ≤ N)

- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-low; clears all state immediately when low
- start  input  1  launch request; sampled only in IDLE
- mode  input  2  0 = shift left, 1 = shift right, 2 = rotate left, 3 = rotate right
- amount  input  CW  total positions to move
- cin  input  1  fill bit for shift modes; ignored for rotates
- pin  input  N  operand word
- pout  output  N  working/result register
- busy  output  1  high while the shift is in progress
- done  output  1  one-cycle pulse; `pout` holds the final result

## Operation
- **Reset** (rst = 0):
  - `pout`, `busy`, `done`, the remaining counter and all latched controls are cleared to 0.
  - State goes to IDLE. Reset takes effect asynchronously, including mid-operation.
- **FSM states:** IDLE, RUN, DONE.
- **IDLE**, on a rising edge with start = 1:
  - Latch `pout` ← `pin`, and latch `mode`, `cin`, and remaining ← `amount`.
  - If `amount` = 0, go to DONE. Otherwise go to RUN.
  - With start = 0, stay in IDLE and hold `pout`.
- **RUN**, on each edge:
  - Let k = min(STEP, remaining). Move `pout` by k positions in the latched mode, then remaining ← remaining − k.
  - When the new remaining is 0, go to DONE. Otherwise stay in RUN.
- **Mode behaviour:**
  - Shift left: `pout` ← {pout[N−1−k:0], k copies of cin}. Shifting all N positions or more yields all cin.
  - Shift right: `pout` ← {k copies of cin, pout[N−1:k]}.
  - Rotate left/right: bits leaving one end re-enter the other. An amount ≥ N wraps naturally (effective amount mod N). No explicit modulo is required, because the stepwise behaviour produces it.
- **DONE:** `done` = 1 for exactly one cycle, `pout` is held, and the next edge goes to IDLE.
- **Ignored inputs:**
  - `start` is ignored in RUN and DONE; it is not queued.
  - `pin`, `mode`, `amount` and `cin` changes after launch have no effect.
- **Registered outputs:**
  - `busy` = 1 exactly while in RUN.
  - `done` = 1 exactly while in DONE.
  - Both are registered, with no combinational path from the inputs.
- **Result holding:** `pout` shows intermediate values during RUN. It keeps the final result in IDLE until the next launch or reset.

## Timing
- **Launch:** the launch edge (L) loads `pout` = `pin`.
- **Run length:** RUN lasts R = ceil(amount / STEP) cycles. `busy` is high for exactly R cycles, starting on the cycle after L.
- **Completion:** `done` is high in the cycle after the final RUN edge, i.e. edge L + R + 1 leaves DONE.
- **Zero amount:** R = 0, `done` is high in the cycle right after L, and `busy` never asserts.
- **Throughput:** one operation per R + 2 cycles. The earliest next launch is the edge after `done` falls, with start sampled in IDLE.
- **Mid-operation reset:** rst low at any point forces `pout` = 0, `busy` = 0, `done` = 0 immediately. Operation resumes only via a new start after rst returns high.
- **Remaining counter:** CW bits wide; it never underflows, because k ≤ remaining.

## Test plan
1. **Rotate left.** N = 25, STEP = 1, mode = 2, pin = 25'h1000001, amount = 3.
   - Required: `busy` high exactly 3 cycles, then `done` pulse with `pout` = 25'h000000C.
2. **Shift left with fill.** mode = 0, cin = 1, pin = 0, amount = 4.
   - Required: intermediate `pout` values 25'h1, 25'h3, 25'h7, then final 25'h000000F at `done`.
3. **Shift right past width.** mode = 1, cin = 0, pin = 25'h1FFFFFF, amount = 30.
   - Required: 30 busy cycles; `pout` = 0 at `done`, and it reaches 0 after the 25th RUN edge.
4. **Zero amount, ignored start.** amount = 0, any mode, pin = 25'h0ABCDEF.
   - Required: `done` in the cycle after launch, `pout` = 25'h0ABCDEF, `busy` never high.
   - Also hold start = 1 through a 5-cycle operation: exactly one operation runs.
5. **Reset mid-run.** Drive rst low during the 2nd RUN cycle of a 5-step rotate.
   - Required: `pout`, `busy` and `done` all 0 before the next clock edge.
   - After release, the block stays IDLE until start.
6. **Multi-step rotate.** Build with STEP = 4; mode = 3, pin = 25'h0000001, amount = 10.
   - Required: steps of 4, 4, 2, so `busy` is high 3 cycles.
   - Final `pout` = 25'h0008000 (bit 15).
